// File: rtl/spkdet_pkg.sv
// -----------------------------------------------------------------------------
// spkdet_pkg
// Shared definitions for the spk_det_nn spike detector:
//   - per-channel detector state type and encodings
//   - nn_slot(): extracts neighbour slot k from a packed neighbour list
// Optional feature macro: SPKDET_REFRACTORY_EN (adds the REFR state encoding).
// -----------------------------------------------------------------------------
package spkdet_pkg;

  typedef logic [1:0] spk_state_t;

  localparam spk_state_t ST_IDLE   = 2'd0;
  localparam spk_state_t ST_FALL   = 2'd1;
  localparam spk_state_t ST_TROUGH = 2'd2;
`ifdef SPKDET_REFRACTORY_EN
  localparam spk_state_t ST_REFR   = 2'd3;
`endif

  // Upper bounds for the generic slot extractor.
  localparam int SPK_CHW_MAX = 16;
  localparam int SPK_NNV_MAX = 512;

  // Returns slot k (chw bits wide) of a packed list, slot k = vec[k*chw +: chw].
  function automatic logic [SPK_CHW_MAX-1:0] nn_slot(input logic [SPK_NNV_MAX-1:0] vec,
                                                     input int k,
                                                     input int chw);
    return SPK_CHW_MAX'(vec >> (k * chw)) & SPK_CHW_MAX'((1 << chw) - 1);
  endfunction

endpackage

// File: rtl/spkdet_ch_mem.sv
// -----------------------------------------------------------------------------
// spkdet_ch_mem
// Per-channel distributed storage for the spike detector: state, running
// minimum Mn and (optionally) the refractory counter.
//   - 1 write port (stage 3), 1 own-channel read port + NUM_NN neighbour Mn
//     read ports (stage 2), all combinational reads
//   - a read of the address being written this cycle returns the write data
//   - after rst_n rises, sweeps every channel to IDLE/0/0, then raises
//     o_init_done one cycle after the last write
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   o_init_done         sweep complete
//   i_we/i_wa/i_w*      write port
//   i_ra, o_rd_*        own-channel read
//   i_ra_nn, o_rd_nn_mn neighbour Mn reads, slot k = [k*CHW +: CHW] / [k*DW +: DW]
// Optional feature macro: SPKDET_REFRACTORY_EN (adds the counter array).
// -----------------------------------------------------------------------------
module spkdet_ch_mem
  import spkdet_pkg::*;
#(
  parameter int NUM_CH = 32,
  parameter int DW     = 32,
  parameter int NUM_NN = 4,
  parameter int REFR_W = 8,
  parameter int CHW    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  o_init_done,
  input  logic                  i_we,
  input  logic [CHW-1:0]        i_wa,
  input  spk_state_t            i_wst,
  input  logic [DW-1:0]         i_wmn,
`ifdef SPKDET_REFRACTORY_EN
  input  logic [REFR_W-1:0]     i_wcnt,
  output logic [REFR_W-1:0]     o_rd_cnt,
`endif
  input  logic [CHW-1:0]        i_ra,
  output spk_state_t            o_rd_state,
  output logic [DW-1:0]         o_rd_mn,
  input  logic [NUM_NN*CHW-1:0] i_ra_nn,
  output logic [NUM_NN*DW-1:0]  o_rd_nn_mn
);

  localparam logic [CHW:0] CH_LIM  = (CHW+1)'(NUM_CH);
  localparam logic [CHW:0] IDX_ONE = (CHW+1)'(1);

  spk_state_t        r_state [NUM_CH];
  logic [DW-1:0]     r_mn    [NUM_CH];
`ifdef SPKDET_REFRACTORY_EN
  logic [REFR_W-1:0] r_cnt   [NUM_CH];
`endif

  logic [CHW:0]      r_init_idx;
  logic              r_init_done;
  logic              w_sweep;
  logic [CHW-1:0]    w_slot [NUM_NN];

  assign o_init_done = r_init_done;
  assign w_sweep     = rst_n && !r_init_done && (r_init_idx < CH_LIM);

  // Index runs 0..NUM_CH: the extra step delays init_done past the last write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
    end else if (!r_init_done) begin
      if (r_init_idx == CH_LIM) r_init_done <= 1'b1;
      else                      r_init_idx  <= r_init_idx + IDX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_sweep) begin
      r_state[r_init_idx[CHW-1:0]] <= ST_IDLE;
      r_mn[r_init_idx[CHW-1:0]]    <= '0;
`ifdef SPKDET_REFRACTORY_EN
      r_cnt[r_init_idx[CHW-1:0]]   <= '0;
`endif
    end else if (i_we) begin
      r_state[i_wa] <= i_wst;
      r_mn[i_wa]    <= i_wmn;
`ifdef SPKDET_REFRACTORY_EN
      r_cnt[i_wa]   <= i_wcnt;
`endif
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_NN; k++) begin
      w_slot[k] = CHW'(nn_slot(SPK_NNV_MAX'(i_ra_nn), k, CHW));
    end
  end

  always_comb begin
    o_rd_state = r_state[i_ra];
    o_rd_mn    = r_mn[i_ra];
`ifdef SPKDET_REFRACTORY_EN
    o_rd_cnt   = r_cnt[i_ra];
`endif
    if (i_we && (i_wa == i_ra)) begin
      o_rd_state = i_wst;
      o_rd_mn    = i_wmn;
`ifdef SPKDET_REFRACTORY_EN
      o_rd_cnt   = i_wcnt;
`endif
    end
    o_rd_nn_mn = '0;
    for (int k = 0; k < NUM_NN; k++) begin
      o_rd_nn_mn[k*DW +: DW] = (i_we && (i_wa == w_slot[k])) ? i_wmn : r_mn[w_slot[k]];
    end
  end

endmodule

// File: rtl/spk_det_nn.sv
// -----------------------------------------------------------------------------
// spk_det_nn
// Multi-channel threshold/trough spike detector with neighbour-minimum check.
// Three-stage pipeline (latency 3 in detect and bypass modes):
//   stage 1 registers inputs, stage 2 registers channel/neighbour reads,
//   stage 3 evaluates, writes back and registers outputs.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   thr_enable            1 = detect, 0 = bypass
//   valid_in, end_of_frame, ch_no, ch_nn, threshold_in, v_in, refr_len  sample in
//   init_done             channel sweep finished (inputs ignored before this)
//   valid_out, ch_out, ch_nn_out, eof_out, v_out, min_out, state_out,
//   is_peak_out           sample out; v_out = {v[DW-1:1], peak}
// Optional feature macro: SPKDET_REFRACTORY_EN (refractory lockout after peak).
//
// state  | meaning
// IDLE   | sample at/above threshold, Mn cleared
// FALL   | below threshold and still reaching new minima
// TROUGH | below threshold, past the minimum (peak candidate already judged)
// REFR   | lockout after a peak, counter running (refractory build only)
// -----------------------------------------------------------------------------
module spk_det_nn
  import spkdet_pkg::*;
#(
  parameter  int NUM_CH = 32,
  parameter  int DW     = 32,
  parameter  int NUM_NN = 4,
  parameter  int REFR_W = 8,
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  thr_enable,
  input  logic                  valid_in,
  input  logic                  end_of_frame,
  input  logic [CHW-1:0]        ch_no,
  input  logic [NUM_NN*CHW-1:0] ch_nn,
  input  logic [DW-1:0]         threshold_in,
  input  logic [DW-1:0]         v_in,
  input  logic [REFR_W-1:0]     refr_len,
  output logic                  init_done,
  output logic                  valid_out,
  output logic [CHW-1:0]        ch_out,
  output logic [NUM_NN*CHW-1:0] ch_nn_out,
  output logic                  eof_out,
  output logic [DW-1:0]         v_out,
  output logic [DW-1:0]         min_out,
  output logic [1:0]            state_out,
  output logic                  is_peak_out
);

  localparam logic [CHW:0] CH_LIM = (CHW+1)'(NUM_CH);

  logic                  w_init_done;

  // stage 1
  logic                  r1_vld, r1_en, r1_eof;
  logic [CHW-1:0]        r1_ch;
  logic [NUM_NN*CHW-1:0] r1_nn;
  logic [DW-1:0]         r1_thr, r1_v;

  // stage 2
  logic                  r2_vld, r2_en, r2_eof;
  logic [CHW-1:0]        r2_ch;
  logic [NUM_NN*CHW-1:0] r2_nn;
  logic [DW-1:0]         r2_thr, r2_v, r2_mn;
  spk_state_t            r2_state;
  logic [NUM_NN*DW-1:0]  r2_nn_mn;
  logic [NUM_NN-1:0]     r2_nn_ok;

  // read data and stage-3 evaluation
  spk_state_t            w_rd_state;
  logic [DW-1:0]         w_rd_mn;
  logic [NUM_NN*DW-1:0]  w_rd_nn_mn;
  logic [CHW-1:0]        w_nn_ch [NUM_NN];
  logic [NUM_NN-1:0]     w_nn_ok;
  logic                  w_we;
  logic                  w_below, w_lt_min, w_nn_pass, w_cand, w_peak;
  spk_state_t            w_nxt_st;
  logic [DW-1:0]         w_nxt_mn;

`ifdef SPKDET_REFRACTORY_EN
  logic [REFR_W-1:0]     r1_refr, r2_refr, r2_cnt;
  logic [REFR_W-1:0]     w_rd_cnt, w_nxt_cnt;
`else
  logic                  w_unused_refr;
  assign w_unused_refr = ^refr_len;
`endif

  assign init_done = w_init_done;
  assign w_we      = r2_vld && r2_en;

  spkdet_ch_mem #(
    .NUM_CH (NUM_CH),
    .DW     (DW),
    .NUM_NN (NUM_NN),
    .REFR_W (REFR_W),
    .CHW    (CHW)
  ) u_mem (
    .clk         (clk),
    .rst_n       (rst_n),
    .o_init_done (w_init_done),
    .i_we        (w_we),
    .i_wa        (r2_ch),
    .i_wst       (w_nxt_st),
    .i_wmn       (w_nxt_mn),
`ifdef SPKDET_REFRACTORY_EN
    .i_wcnt      (w_nxt_cnt),
    .o_rd_cnt    (w_rd_cnt),
`endif
    .i_ra        (r1_ch),
    .o_rd_state  (w_rd_state),
    .o_rd_mn     (w_rd_mn),
    .i_ra_nn     (r1_nn),
    .o_rd_nn_mn  (w_rd_nn_mn)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_vld <= 1'b0;
      r1_en  <= 1'b0;
      r1_eof <= 1'b0;
      r1_ch  <= '0;
      r1_nn  <= '0;
      r1_thr <= '0;
      r1_v   <= '0;
`ifdef SPKDET_REFRACTORY_EN
      r1_refr <= '0;
`endif
    end else begin
      r1_vld <= valid_in && w_init_done;
      r1_en  <= thr_enable;
      r1_eof <= end_of_frame;
      r1_ch  <= ch_no;
      r1_nn  <= ch_nn;
      r1_thr <= threshold_in;
      r1_v   <= v_in;
`ifdef SPKDET_REFRACTORY_EN
      r1_refr <= refr_len;
`endif
    end
  end

  // Self slots and out-of-range slots never veto a peak.
  always_comb begin
    for (int k = 0; k < NUM_NN; k++) begin
      w_nn_ch[k] = CHW'(nn_slot(SPK_NNV_MAX'(r1_nn), k, CHW));
      w_nn_ok[k] = (w_nn_ch[k] != r1_ch) && ({1'b0, w_nn_ch[k]} < CH_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r2_vld   <= 1'b0;
      r2_en    <= 1'b0;
      r2_eof   <= 1'b0;
      r2_ch    <= '0;
      r2_nn    <= '0;
      r2_thr   <= '0;
      r2_v     <= '0;
      r2_mn    <= '0;
      r2_state <= ST_IDLE;
      r2_nn_mn <= '0;
      r2_nn_ok <= '0;
`ifdef SPKDET_REFRACTORY_EN
      r2_refr  <= '0;
      r2_cnt   <= '0;
`endif
    end else begin
      r2_vld   <= r1_vld;
      r2_en    <= r1_en;
      r2_eof   <= r1_eof;
      r2_ch    <= r1_ch;
      r2_nn    <= r1_nn;
      r2_thr   <= r1_thr;
      r2_v     <= r1_v;
      r2_mn    <= w_rd_mn;
      r2_state <= w_rd_state;
      r2_nn_mn <= w_rd_nn_mn;
      r2_nn_ok <= w_nn_ok;
`ifdef SPKDET_REFRACTORY_EN
      r2_refr  <= r1_refr;
      r2_cnt   <= w_rd_cnt;
`endif
    end
  end

  // r2_mn is the minimum before this sample's update (Min).
  always_comb begin
    w_below   = $signed(r2_v) < $signed(r2_thr);
    w_lt_min  = $signed(r2_v) < $signed(r2_mn);
    w_nn_pass = 1'b1;
    for (int k = 0; k < NUM_NN; k++) begin
      if (r2_nn_ok[k] && ($signed(r2_mn) > $signed(r2_nn_mn[k*DW +: DW]))) w_nn_pass = 1'b0;
    end
    w_cand   = 1'b0;
    w_nxt_st = r2_state;
    w_nxt_mn = !w_below ? '0 : (w_lt_min ? r2_v : r2_mn);
`ifdef SPKDET_REFRACTORY_EN
    w_nxt_cnt = r2_cnt;
`endif
    case (r2_state)
      ST_IDLE:   w_nxt_st = w_below ? ST_FALL : ST_IDLE;
      ST_FALL: begin
        if (!w_below)     w_nxt_st = ST_IDLE;
        else if (w_lt_min) w_nxt_st = ST_FALL;
        else begin
          w_nxt_st = ST_TROUGH;
          w_cand   = 1'b1;
        end
      end
      ST_TROUGH: begin
        if (!w_below)      w_nxt_st = ST_IDLE;
        else if (w_lt_min) w_nxt_st = ST_FALL;
        else               w_nxt_st = ST_TROUGH;
      end
`ifdef SPKDET_REFRACTORY_EN
      ST_REFR: begin
        w_nxt_cnt = (r2_cnt == '0) ? '0 : r2_cnt - REFR_W'(1);
        w_nxt_st  = ((r2_cnt == '0) && !w_below) ? ST_IDLE : ST_REFR;
      end
`endif
      default:   w_nxt_st = ST_IDLE;
    endcase
    w_peak = w_cand && w_nn_pass;
`ifdef SPKDET_REFRACTORY_EN
    if (w_peak) begin
      w_nxt_st  = ST_REFR;
      w_nxt_cnt = r2_refr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out   <= 1'b0;
      ch_out      <= '0;
      ch_nn_out   <= '0;
      eof_out     <= 1'b0;
      v_out       <= '0;
      min_out     <= '0;
      state_out   <= '0;
      is_peak_out <= 1'b0;
    end else begin
      valid_out <= r2_vld;
      ch_out    <= r2_ch;
      ch_nn_out <= r2_nn;
      eof_out   <= r2_eof;
      if (r2_en) begin
        v_out       <= {r2_v[DW-1:1], w_peak};
        min_out     <= w_nxt_mn;
        state_out   <= w_nxt_st;
        is_peak_out <= w_peak && r2_vld;
      end else begin
        v_out       <= r2_v;
        min_out     <= '0;
        state_out   <= ST_IDLE;
        is_peak_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spk_det_nn.sv
// -----------------------------------------------------------------------------
// tb_spk_det_nn
// Directed bench for spk_det_nn; expected beats are queued with the cycle on
// which they must appear and compared by a negedge monitor.
// Builds with or without SPKDET_REFRACTORY_EN.
// -----------------------------------------------------------------------------
module tb_spk_det_nn;

  localparam int NUM_CH = 32;
  localparam int DW     = 32;
  localparam int NUM_NN = 4;
  localparam int REFR_W = 8;
  localparam int CHW    = 5;

`ifdef SPKDET_REFRACTORY_EN
  localparam logic [1:0] PK_ST = 2'd3;
`else
  localparam logic [1:0] PK_ST = 2'd2;
`endif

  logic                  clk;
  logic                  rst_n;
  logic                  thr_enable;
  logic                  valid_in;
  logic                  end_of_frame;
  logic [CHW-1:0]        ch_no;
  logic [NUM_NN*CHW-1:0] ch_nn;
  logic [DW-1:0]         threshold_in;
  logic [DW-1:0]         v_in;
  logic [REFR_W-1:0]     refr_len;
  logic                  init_done;
  logic                  valid_out;
  logic [CHW-1:0]        ch_out;
  logic [NUM_NN*CHW-1:0] ch_nn_out;
  logic                  eof_out;
  logic [DW-1:0]         v_out;
  logic [DW-1:0]         min_out;
  logic [1:0]            state_out;
  logic                  is_peak_out;

  spk_det_nn #(
    .NUM_CH (NUM_CH),
    .DW     (DW),
    .NUM_NN (NUM_NN),
    .REFR_W (REFR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .thr_enable   (thr_enable),
    .valid_in     (valid_in),
    .end_of_frame (end_of_frame),
    .ch_no        (ch_no),
    .ch_nn        (ch_nn),
    .threshold_in (threshold_in),
    .v_in         (v_in),
    .refr_len     (refr_len),
    .init_done    (init_done),
    .valid_out    (valid_out),
    .ch_out       (ch_out),
    .ch_nn_out    (ch_nn_out),
    .eof_out      (eof_out),
    .v_out        (v_out),
    .min_out      (min_out),
    .state_out    (state_out),
    .is_peak_out  (is_peak_out)
  );

  typedef struct {
    int                    cyc;
    logic [CHW-1:0]        ch;
    logic [NUM_NN*CHW-1:0] nn;
    logic                  eof;
    logic [1:0]            st;
    logic [DW-1:0]         mn;
    logic                  chk_mn;
    logic [DW-1:0]         vout;
    logic                  pk;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  logic              g_en;
  logic              g_eof;
  logic [DW-1:0]     g_thr;
  logic [REFR_W-1:0] g_refr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_cnt);
    end
  endtask

  function automatic logic [NUM_NN*CHW-1:0] mk_nn(input int a, input int b, input int c, input int d);
    return {CHW'(d), CHW'(c), CHW'(b), CHW'(a)};
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      if (q.size() == 0) begin
        chk("unexp_vo", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("lat",   cyc_cnt,     e.cyc);
        chk("ch",    ch_out,      e.ch);
        chk("nn",    ch_nn_out,   e.nn);
        chk("eof",   eof_out,     e.eof);
        chk("state", state_out,   e.st);
        if (e.chk_mn) chk("min", min_out, e.mn);
        chk("vout",  v_out,       e.vout);
        chk("peak",  is_peak_out, e.pk);
      end
    end
  end

  // Called just after a posedge; drives one sample for one cycle.
  task automatic send(input logic [CHW-1:0] ch, input logic [NUM_NN*CHW-1:0] nn,
                      input logic [DW-1:0] v, input logic [1:0] est,
                      input logic [DW-1:0] emn, input logic epk);
    exp_t e;
    ch_no        = ch;
    ch_nn        = nn;
    v_in         = v;
    threshold_in = g_thr;
    thr_enable   = g_en;
    end_of_frame = g_eof;
    refr_len     = g_refr;
    valid_in     = 1'b1;
    e.cyc    = cyc_cnt + 3;
    e.ch     = ch;
    e.nn     = nn;
    e.eof    = g_eof;
    e.st     = est;
    e.mn     = emn;
    e.chk_mn = g_en;
    e.vout   = g_en ? {v[DW-1:1], epk} : v;
    e.pk     = epk;
    q.push_back(e);
    @(posedge clk); #1;
    valid_in     = 1'b0;
    end_of_frame = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Called right after rst_n rises; keeps valid_in high through the sweep.
  task automatic wait_init();
    int cyc;
    cyc          = 0;
    valid_in     = 1'b1;
    thr_enable   = 1'b1;
    v_in         = -32'sd999;
    threshold_in = -32'sd100;
    ch_no        = 5'd3;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk("sweep_vo", valid_out, 0);
    end while (!init_done && cyc < 200);
    valid_in = 1'b0;
    chk("init_lat", cyc, NUM_CH + 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [NUM_NN*CHW-1:0] nn_a, nn_b, nn_s, nn_f;
    nn_a = mk_nn(10, 11, 12, 13);
    nn_b = mk_nn(4, 10, 11, 12);
    nn_s = mk_nn(3, 3, 3, 3);
    nn_f = mk_nn(7, 10, 11, 12);

    rst_n = 1'b0; thr_enable = 1'b0; valid_in = 1'b0; end_of_frame = 1'b0;
    ch_no = '0; ch_nn = '0; threshold_in = '0; v_in = '0; refr_len = '0;
    g_en = 1'b1; g_eof = 1'b0; g_thr = -32'sd100; g_refr = '0;

    // reset state and init sweep
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_idone", init_done, 0);
    chk("rst_vo",    valid_out, 0);
    chk("rst_vout",  v_out,     0);
    chk("rst_min",   min_out,   0);
    chk("rst_state", state_out, 0);
    chk("rst_peak",  is_peak_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init();

    // basic trough on ch3, eof on the peak beat
    send(3, nn_a,   32'sd0, 2'd0,    32'sd0, 1'b0); gap(2);
    send(3, nn_a, -32'sd150, 2'd1, -32'sd150, 1'b0); gap(2);
    send(3, nn_a, -32'sd300, 2'd1, -32'sd300, 1'b0); gap(2);
    g_eof = 1'b1;
    send(3, nn_a, -32'sd200, PK_ST, -32'sd300, 1'b1); gap(2);
    g_eof = 1'b0;

    // deeper neighbour ch4 vetoes the peak; self slots are ignored
    send(4, nn_s,  -32'sd400, 2'd1, -32'sd400, 1'b0); gap(2);
    send(3, nn_a,    32'sd0, 2'd0,    32'sd0, 1'b0); gap(2);
    send(3, nn_b, -32'sd150, 2'd1, -32'sd150, 1'b0); gap(2);
    send(3, nn_b, -32'sd300, 2'd1, -32'sd300, 1'b0); gap(2);
    send(3, nn_b, -32'sd200, 2'd2, -32'sd300, 1'b0); gap(2);
    send(3, nn_a,    32'sd0, 2'd0,    32'sd0, 1'b0); gap(2);
    send(3, nn_s, -32'sd150, 2'd1, -32'sd150, 1'b0); gap(2);
    send(3, nn_s, -32'sd300, 2'd1, -32'sd300, 1'b0); gap(2);
    send(3, nn_s, -32'sd200, PK_ST, -32'sd300, 1'b1); gap(2);

    // back-to-back on one channel
    send(6, nn_a, -32'sd150, 2'd1, -32'sd150, 1'b0);
    send(6, nn_a, -32'sd300, 2'd1, -32'sd300, 1'b0);
    send(6, nn_a, -32'sd200, PK_ST, -32'sd300, 1'b1); gap(3);

    // neighbour written on the previous cycle must be seen
    send(8, nn_a, -32'sd150, 2'd1, -32'sd150, 1'b0); gap(2);
    send(8, nn_a, -32'sd300, 2'd1, -32'sd300, 1'b0); gap(2);
    send(7, nn_a, -32'sd400, 2'd1, -32'sd400, 1'b0);
    send(8, nn_f, -32'sd200, 2'd2, -32'sd300, 1'b0); gap(3);

    // post-peak behaviour, refr_len = 2
    g_refr = 8'd2;
    send(9, nn_a, -32'sd150, 2'd1, -32'sd150, 1'b0); gap(2);
    send(9, nn_a, -32'sd300, 2'd1, -32'sd300, 1'b0); gap(2);
    send(9, nn_a, -32'sd200, PK_ST, -32'sd300, 1'b1); gap(2);
`ifdef SPKDET_REFRACTORY_EN
    send(9, nn_a, -32'sd500, 2'd3, -32'sd500, 1'b0); gap(2);
    send(9, nn_a, -32'sd600, 2'd3, -32'sd600, 1'b0); gap(2);
    send(9, nn_a, -32'sd400, 2'd3, -32'sd600, 1'b0); gap(2);
    send(9, nn_a,   32'sd10, 2'd0,    32'sd0, 1'b0); gap(2);
    send(9, nn_a, -32'sd150, 2'd1, -32'sd150, 1'b0); gap(2);
    // counter must expire before an above-threshold sample releases REFR
    send(10, nn_a, -32'sd150, 2'd1, -32'sd150, 1'b0); gap(2);
    send(10, nn_a, -32'sd300, 2'd1, -32'sd300, 1'b0); gap(2);
    send(10, nn_a, -32'sd200, 2'd3, -32'sd300, 1'b1); gap(2);
    send(10, nn_a,   32'sd10, 2'd3,    32'sd0, 1'b0); gap(2);
    send(10, nn_a,   32'sd10, 2'd3,    32'sd0, 1'b0); gap(2);
    send(10, nn_a,   32'sd10, 2'd0,    32'sd0, 1'b0); gap(2);
`else
    send(9, nn_a, -32'sd500, 2'd1, -32'sd500, 1'b0); gap(2);
    send(9, nn_a, -32'sd600, 2'd1, -32'sd600, 1'b0); gap(2);
    send(9, nn_a,   32'sd10, 2'd0,    32'sd0, 1'b0); gap(2);
    send(9, nn_a, -32'sd150, 2'd1, -32'sd150, 1'b0); gap(2);
`endif
    g_refr = 8'd0;

    // bypass leaves ch3 untouched (still Mn=-300 past its trough)
    g_en = 1'b0;
    send(3, nn_a, -32'sd7, 2'd0, 32'sd0, 1'b0); gap(2);
    g_en = 1'b1;
    send(3, nn_a, -32'sd250, PK_ST, -32'sd300, 1'b0); gap(3);

    // reset with a sample in flight, then re-sweep clears ch3
    ch_no = 5'd3; ch_nn = nn_a; v_in = -32'sd123; threshold_in = -32'sd100;
    thr_enable = 1'b1; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_idone", init_done, 0);
    chk("mid_rst_vo",    valid_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init();
    send(3, nn_a, -32'sd150, 2'd1, -32'sd150, 1'b0); gap(5);

    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
